alu_exec: RTL and testbench
===========================

# alu_exec

Registered execute stage of the multi-cycle 16-bit CPU datapath. It consumes the 4-bit ALU operation code produced by the ALU control decoder, together with two operands from the register-read/immediate stage. It performs the operation and holds the result in an output register (the ALUOut register) with flags, under a valid/ready handshake so the control FSM or a stall can back-pressure it. It also keeps a retired-operation counter for debug.

## Interface
- WORD_SIZE, 16, datapath width; all arithmetic rules below assume 16.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; discards the held result.
- in_valid  input  1  op/a/b are valid this cycle.
- in_ready  output  1  stage can accept an operation this cycle.
- op  input  4  ALU operation code from the ALU control decoder.
- a  input  16  operand A (rs).
- b  input  16  operand B (rt or extended immediate).
- out_valid  output  1  result/flags registers hold an unconsumed result.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  16  registered ALU result.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow; ADD/SUB only, else 0.
- equal  output  1  a == b of the accepted operation, used for BEQ/BNE.
- illegal  output  1  op was an undefined encoding.
- ops_done  output  16  count of output handshakes; wraps.

## Operation
- Op encodings:
  - 0x0 ADD: a+b mod 2^16.
  - 0x1 SUB: a−b mod 2^16.
  - 0x5 AND: a&b.
  - 0x6 OR: a|b.
  - 0x9 NOT: ~a.
  - 0xA SHR: arithmetic shift right by one, {a[15],a[15:1]}.
  - 0xC TCP: 0−a.
  - 0xD SHL: {a[14:0],1'b0}.
  - 0xF LHI: {b[7:0],8'h00}.
- Undefined ops (0x2,0x3,0x4,0x7,0x8,0xB,0xE): result 0x0000, illegal=1, zero=1, overflow=0. The op still completes a normal handshake.
- Overflow rules:
  - ADD: a[15]==b[15] and result[15]!=a[15].
  - SUB: a[15]!=b[15] and result[15]!=a[15].
  - TCP of 0x8000 gives 0x8000 with overflow=0 (not flagged).
- equal is computed from a and b regardless of op.
- The stage is a single-entry output register (two states):
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- in_ready = !flush && (!out_valid || out_ready).
- Accept = in_valid && in_ready.
  - EMPTY + accept → FULL.
  - FULL + out_ready without accept → EMPTY.
  - FULL + out_ready + accept → FULL with the new result (back-to-back, no bubble).
  - FULL + !out_ready → hold all outputs stable. in_ready=0.
- flush: next state EMPTY and no accept that cycle. flush takes priority over a simultaneous in_valid and out_ready. ops_done does not increment for the flushed result.
- ops_done increments by 1 on each cycle with out_valid && out_ready && !flush. It wraps from 0xFFFF to 0x0000.

## Timing
- Latency 1: an op accepted at edge N shows on result/flags with out_valid=1 after edge N. Throughput 1 op/cycle when out_ready=1.
- All outputs are registered except in_ready, which is combinational from out_valid, out_ready and flush.
- Reset (reset_n=0, any time, including mid-handshake):
  - out_valid=0, result=0x0000, zero=0, overflow=0, equal=0, illegal=0, ops_done=0x0000.
  - in_ready follows its equation (1 while in reset, given flush=0).
- Result/flag registers load only on accept. They keep their last value while EMPTY.

## Test plan
- ADD a=0x7FFF, b=0x0001 → result 0x8000, overflow=1, zero=0, out_valid one cycle after accept.
- SUB a=0x0005, b=0x0005 → result 0x0000, zero=1, equal=1, overflow=0. Then TCP a=0x0001 → 0xFFFF.
- Shift and LHI:
  - SHR a=0x8002 → 0xC001.
  - SHL a=0x8001 → 0x0002.
  - LHI b=0x12AB → 0xAB00.
  - Undefined op 0x3 → result 0, illegal=1.
- Back-pressure: hold out_ready=0 with out_valid=1 for 3 cycles → in_ready=0, result stable. Release → next op accepted the same cycle, ops_done +1.
- flush while FULL with in_valid=1, out_ready=1 → out_valid=0 next cycle, input not accepted, ops_done unchanged.
- Drive 0x10000 handshakes → ops_done wraps to 0x0000. Assert reset_n=0 mid-stream → all outputs at reset values immediately, asynchronously.

Source files
------------

// File: rtl/alu_exec_if.sv
// Handshake and data bundle for the execute-stage ALU.
// Master drives operations and consumes results; slave is the stage.
interface alu_exec_if #(
    parameter int WORD_SIZE = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           op;
    logic [WORD_SIZE-1:0] a;
    logic [WORD_SIZE-1:0] b;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] result;
    logic                 zero;
    logic                 overflow;
    logic                 equal;
    logic                 illegal;
    logic [15:0]          ops_done;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero,
        input  overflow, equal, illegal, ops_done
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero,
        output overflow, equal, illegal, ops_done
    );
endinterface

// File: rtl/alu_exec.sv
// Registered execute stage: ALU plus single-entry result register
// with valid/ready handshake and a retired-operation counter.
module alu_exec #(
    parameter int WORD_SIZE = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    alu_exec_if.slave   bus
);
    localparam int W = WORD_SIZE;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_TCP = 4'hC;
    localparam logic [3:0] OP_SHL = 4'hD;
    localparam logic [3:0] OP_LHI = 4'hF;

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   result_q, result_d;
    logic           zero_q, zero_d;
    logic           overflow_q, overflow_d;
    logic           equal_q, equal_d;
    logic           illegal_q, illegal_d;
    logic [15:0]    ops_done_q, ops_done_d;

    logic [W-1:0]   alu_res;
    logic           alu_ovf;
    logic           alu_ill;
    logic           in_ready;
    logic           accept;
    logic           out_valid;

    // Combinational ALU on the presented operands.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        unique case (bus.op)
            OP_ADD: begin
                alu_res = bus.a + bus.b;
                alu_ovf = (bus.a[W-1] == bus.b[W-1]) &&
                          (alu_res[W-1] != bus.a[W-1]);
            end
            OP_SUB: begin
                alu_res = bus.a - bus.b;
                alu_ovf = (bus.a[W-1] != bus.b[W-1]) &&
                          (alu_res[W-1] != bus.a[W-1]);
            end
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_NOT: alu_res = ~bus.a;
            OP_SHR: alu_res = {bus.a[W-1], bus.a[W-1:1]};
            OP_TCP: alu_res = '0 - bus.a;
            OP_SHL: alu_res = {bus.a[W-2:0], 1'b0};
            OP_LHI: alu_res = {bus.b[7:0], {(W-8){1'b0}}};
            default: alu_ill = 1'b1;
        endcase
    end

    assign out_valid = (state_q == S_FULL);
    assign in_ready  = !flush && (!out_valid || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;

    // Next state, result loading and retire counting.
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        equal_d    = equal_q;
        illegal_d  = illegal_q;
        ops_done_d = ops_done_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            if (out_valid && bus.out_ready) begin
                ops_done_d = ops_done_q + 16'd1;
                state_d    = S_EMPTY;
            end
            if (accept) begin
                state_d    = S_FULL;
                result_d   = alu_res;
                zero_d     = (alu_res == '0);
                overflow_d = alu_ovf;
                equal_d    = (bus.a == bus.b);
                illegal_d  = alu_ill;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_EMPTY;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            equal_q    <= 1'b0;
            illegal_q  <= 1'b0;
            ops_done_q <= '0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            equal_q    <= equal_d;
            illegal_q  <= illegal_d;
            ops_done_q <= ops_done_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
    assign bus.equal     = equal_q;
    assign bus.illegal   = illegal_q;
    assign bus.ops_done  = ops_done_q;
endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: vector table, scoreboard monitor,
// back-pressure, flush, counter wrap and async reset sequences.
module tb_alu_exec;
    logic clk;
    logic reset_n;
    logic flush;

    alu_exec_if #(.WORD_SIZE(16)) bus ();

    alu_exec #(.WORD_SIZE(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic [15:0] result;
        logic        zero;
        logic        ovf;
        logic        eq;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        exp_t        exp;
    } vec_t;

    int asserts = 0;
    int fails   = 0;
    exp_t sb[$];
    vec_t vecs[13];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [3:0] op,
                                   input logic [15:0] a,
                                   input logic [15:0] b);
        exp_t e;
        int s;
        logic signed [15:0] sa;
        e = '0;
        s = 0;
        sa = a;
        case (op)
            4'h0: begin
                s = int'($signed(a)) + int'($signed(b));
                e.result = s[15:0];
                e.ovf = (s > 32767) || (s < -32768);
            end
            4'h1: begin
                s = int'($signed(a)) - int'($signed(b));
                e.result = s[15:0];
                e.ovf = (s > 32767) || (s < -32768);
            end
            4'h5: e.result = a & b;
            4'h6: e.result = a | b;
            4'h9: e.result = a ^ 16'hFFFF;
            4'hA: e.result = 16'(sa >>> 1);
            4'hC: e.result = 16'(17'h10000 - {1'b0, a});
            4'hD: e.result = a << 1;
            4'hF: e.result = b << 8;
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.result == 16'h0000);
        e.eq = (a == b);
        return e;
    endfunction

    function automatic exp_t dut_out();
        exp_t e;
        e.result = bus.result;
        e.zero = bus.zero;
        e.ovf = bus.overflow;
        e.eq = bus.equal;
        e.ill = bus.illegal;
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on output handshake.
    always @(negedge clk) begin
        logic full;
        logic exp_ready;
        exp_t got;
        exp_t want;
        if (!reset_n) begin
            sb.delete();
        end else begin
            full = (sb.size() != 0);
            exp_ready = !flush && (!full || bus.out_ready);
            chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            chk("out_valid", 32'(bus.out_valid), 32'(full));
            if (flush) begin
                if (full) sb.delete(0);
            end else begin
                if (full && bus.out_ready) begin
                    want = sb.pop_front();
                    got = dut_out();
                    chk("sb_result", 32'(got), 32'(want));
                end
                if (bus.in_valid && exp_ready)
                    sb.push_back(model(bus.op, bus.a, bus.b));
            end
        end
    end

    initial begin
        logic [15:0] snap;

        vecs[0]  = '{4'h0, 16'h7FFF, 16'h0001, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[1]  = '{4'h1, 16'h0005, 16'h0005, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[2]  = '{4'hC, 16'h0001, 16'h0000, '{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[3]  = '{4'hA, 16'h8002, 16'h0000, '{16'hC001, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[4]  = '{4'hD, 16'h8001, 16'h0000, '{16'h0002, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[5]  = '{4'hF, 16'h0000, 16'h12AB, '{16'hAB00, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[6]  = '{4'h3, 16'h1234, 16'h1234, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b1}};
        vecs[7]  = '{4'hC, 16'h8000, 16'h0000, '{16'h8000, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[8]  = '{4'h1, 16'h8000, 16'h0001, '{16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[9]  = '{4'h5, 16'hF0F0, 16'hFF00, '{16'hF000, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[10] = '{4'h6, 16'hF0F0, 16'h0F0F, '{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[11] = '{4'h9, 16'h00FF, 16'h0000, '{16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[12] = '{4'h0, 16'hFFFF, 16'h0001, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}};

        reset_n = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.op = 4'h0;
        bus.a = 16'h0;
        bus.b = 16'h0;
        bus.out_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_outputs", 32'(dut_out()), 32'd0);
        chk("rst_ops_done", 32'(bus.ops_done), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Table: one op, check after one edge, then drain.
        for (int i = 0; i < 13; i++) begin
            bus.op = vecs[i].op;
            bus.a = vecs[i].a;
            bus.b = vecs[i].b;
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d_out", i), 32'(dut_out()), 32'(vecs[i].exp));
            step();
        end
        chk("table_ops_done", 32'(bus.ops_done), 32'd13);

        // Back-pressure: hold for three cycles, then release.
        bus.out_ready = 1'b0;
        bus.op = 4'h0; bus.a = 16'h0001; bus.b = 16'h0002;
        bus.in_valid = 1'b1;
        step();
        bus.op = 4'h1; bus.a = 16'h000A; bus.b = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_result", 32'(bus.result), 32'h0003);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            step();
        end
        snap = bus.ops_done;
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("bp_new_result", 32'(bus.result), 32'h0007);
        chk("bp_ops_done", 32'(bus.ops_done), 32'(snap + 16'd1));
        step();

        // Flush while full with a competing accept.
        bus.out_ready = 1'b0;
        bus.op = 4'h5; bus.a = 16'h0FF0; bus.b = 16'h00FF;
        bus.in_valid = 1'b1;
        step();
        snap = bus.ops_done;
        flush = 1'b1;
        bus.out_ready = 1'b1;
        bus.op = 4'h6;
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_ops_done", 32'(bus.ops_done), 32'(snap));
        chk("flush_result_kept", 32'(bus.result), 32'h00F0);
        step();

        // Counter wrap from a fresh reset.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            bus.op = 4'($urandom);
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
        chk("wrap_ffff", 32'(bus.ops_done), 32'h0000FFFF);
        step();
        chk("wrap_zero", 32'(bus.ops_done), 32'h0);

        // Asynchronous reset mid-stream.
        bus.op = 4'h0; bus.a = 16'h0100; bus.b = 16'h0001;
        bus.in_valid = 1'b1;
        step();
        step();
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("pre_rst_result", 32'(bus.result), 32'h0101);
        #1 reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.out_valid), 32'd0);
        chk("async_outputs", 32'(dut_out()), 32'd0);
        chk("async_ops_done", 32'(bus.ops_done), 32'd0);
        chk("async_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end
endmodule
